// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and access sequencer for the
// single-port 256-word data memory. Port 0 is the core load/store path,
// port 1 a secondary master (debug/DMA). Each grant runs
// IDLE -> ACCESS -> RESP, or IDLE -> RESP for an out-of-range address.
// Optional feature: define DMEM_ARB_FIXED_PRIO_EN to give port 0 fixed
// priority instead of round-robin arbitration.
module dmem_arbiter #(
  parameter int AW = 8,   // implemented word-address width, must be < 32
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rq0_req,
  input  logic          rq0_we,
  input  logic [31:0]   rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  output logic          rq0_ack,
  output logic          rq0_err,
  output logic [DW-1:0] rq0_rdata,
  input  logic          rq1_req,
  input  logic          rq1_we,
  input  logic [31:0]   rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rq1_ack,
  output logic          rq1_err,
  output logic [DW-1:0] rq1_rdata,
  output logic [31:0]   mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          win_q;       // granted port
  logic          we_q;
  logic          err_q;
  logic          rr_ptr_q;    // port that wins a tie
  logic [31:0]   addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic          any_req;
  logic          win_d;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_oor;
  logic          resp_ack;
  logic [DW-1:0] resp_rdata;

  assign any_req = rq0_req | rq1_req;

  // Pick the winner among the pending requests.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    win_d = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // rr_ptr_q is held at 0 in this build, so port 0 wins every tie.
    win_d = ~rq0_req | rr_ptr_q;
`else
    if (rq0_req && rq1_req) begin
      win_d = rr_ptr_q;
    end else begin
      win_d = ~rq0_req;
    end
`endif
  end

  // Route the winner's access fields and range-check its address.
  always_comb begin
    sel_we    = win_d ? rq1_we    : rq0_we;
    sel_addr  = win_d ? rq1_addr  : rq0_addr;
    sel_wdata = win_d ? rq1_wdata : rq0_wdata;
    sel_oor   = |sel_addr[31:AW];
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = sel_oor ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the latched access, read capture and tie pointer.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q   <= win_d;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= sel_oor;
          end
        end
        ACCESS: begin
          if (!we_q) rdata_q <= mem_read_data;
        end
        RESP: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          rr_ptr_q <= 1'b0;
`else
          rr_ptr_q <= ~win_q;
`endif
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and bus are live only during ACCESS; reset forces IDLE
  // asynchronously, which drops them immediately.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (state_q == ACCESS) begin
      mem_read       = ~we_q;
      mem_write      = we_q;
      mem_address    = addr_q;
      mem_write_data = wdata_q;
    end
  end

  // One-cycle acknowledge with error flag and read data to the winner.
  always_comb begin
    resp_ack   = (state_q == RESP);
    resp_rdata = (!we_q && !err_q) ? rdata_q : '0;
    rq0_ack    = resp_ack & ~win_q;
    rq1_ack    = resp_ack &  win_q;
    rq0_err    = rq0_ack & err_q;
    rq1_err    = rq1_ack & err_q;
    rq0_rdata  = rq0_ack ? resp_rdata : '0;
    rq1_rdata  = rq1_ack ? resp_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter. Stimulus
// pushes the expected acknowledge of every access; a monitor pops and
// compares whenever an ack appears. Build with DMEM_ARB_FIXED_PRIO_EN to
// check the fixed-priority variant.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rq0_req = 1'b0, rq0_we = 1'b0;
  logic [31:0]   rq0_addr = '0;
  logic [DW-1:0] rq0_wdata = '0;
  logic          rq0_ack, rq0_err;
  logic [DW-1:0] rq0_rdata;
  logic          rq1_req = 1'b0, rq1_we = 1'b0;
  logic [31:0]   rq1_addr = '0;
  logic [DW-1:0] rq1_wdata = '0;
  logic          rq1_ack, rq1_err;
  logic [DW-1:0] rq1_rdata;
  logic [31:0]   mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_read_data;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ack(rq0_ack), .rq0_err(rq0_err), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ack(rq1_ack), .rq1_err(rq1_err), .rq1_rdata(rq1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded with word = index, synchronous write,
  // combinational read.
  logic [DW-1:0] mem [256];
  assign mem_read_data = mem[mem_address[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
    end
  end

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack0"},   32'(rq0_ack),   32'd0);
    check({tag, "_ack1"},   32'(rq1_ack),   32'd0);
    check({tag, "_err0"},   32'(rq0_err),   32'd0);
    check({tag, "_err1"},   32'(rq1_err),   32'd0);
    check({tag, "_rdata0"}, rq0_rdata,      32'd0);
    check({tag, "_rdata1"}, rq1_rdata,      32'd0);
    check({tag, "_mem_rd"}, 32'(mem_read),  32'd0);
    check({tag, "_mem_wr"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_ad"}, mem_address,    32'd0);
    check({tag, "_mem_wd"}, mem_write_data, 32'd0);
  endtask

  // Monitor: strobe exclusivity every cycle, ack contents against scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        strobe_cnt++;
        check("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
      end
      if (rq0_ack || rq1_ack) begin
        check("single_ack", 32'(rq0_ack & rq1_ack), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected none", rq0_ack, rq1_ack);
        end else begin
          e = exp_q.pop_front();
          check("ack_port",  32'(rq1_ack), 32'(e.port));
          check("ack_err",   32'(e.port ? rq1_err : rq0_err), 32'(e.err));
          check("ack_rdata", e.port ? rq1_rdata : rq0_rdata, e.rdata);
          check("other_rdata", e.port ? rq0_rdata : rq1_rdata, 32'd0);
        end
      end
    end
  end

  task automatic set_req(input bit port, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      rq1_req = req; rq1_we = we; rq1_addr = addr; rq1_wdata = wdata;
    end else begin
      rq0_req = req; rq0_we = we; rq0_addr = addr; rq0_wdata = wdata;
    end
  endtask

  // One access: starts in an IDLE cycle, checks latency, the bus during
  // ACCESS and the number of strobe cycles; drops req in the ack cycle.
  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_err,
                        input logic [31:0] exp_rdata);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    e.port = port; e.err = exp_err; e.rdata = exp_rdata;
    exp_q.push_back(e);
    strobe_cnt = 0;
    set_req(port, 1'b1, we, addr, wdata);
    got = 1'b0;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        check("bus_addr", mem_address, addr);
        check("bus_we",   32'(mem_write), 32'(we));
        check("bus_wdata", mem_write_data, we ? wdata : 32'd0);
      end
      if (port ? rq1_ack : rq0_ack) begin
        got = 1'b1;
        break;
      end
    end
    set_req(port, 1'b0, 1'b0, 32'd0, 32'd0);
    check("latency", got ? 32'(lat) : 32'd99, exp_err ? 32'd1 : 32'd2);
    check("strobe_count", 32'(strobe_cnt), exp_err ? 32'd0 : 32'd1);
  endtask

  initial begin
    exp_t e;
    int   n_ack;
    int   cyc;
    int   t1, t2;

    // Reset state.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // Both ports read continuously: 0,1,0,1 (fixed priority: 0,0,0,0).
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      e.port = 1'b0; e.err = 1'b0; e.rdata = 32'h3;
`else
      e.port = (i % 2 == 1); e.err = 1'b0; e.rdata = (i % 2 == 1) ? 32'h7 : 32'h3;
`endif
      exp_q.push_back(e);
    end
    set_req(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 32'd7, 32'd0);
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (rq0_ack || rq1_ack) n_ack++;
    end
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check("rr_ack_count", 32'(n_ack), 32'd4);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 1 still gets served once port 0 goes quiet.
    access(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 32'h7);
`endif

    // Write then read back through port 0.
    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0);
    check("mem5_written", mem[5], 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);

    // Top in-range word, then out-of-range accesses.
    access(1'b1, 1'b1, 32'hFF, 32'hCAFEF00D, 1'b0, 32'd0);
    access(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 32'd0);
    access(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0000AAAA, 1'b1, 32'd0);
    access(1'b0, 1'b0, 32'hFF, 32'd0, 1'b0, 32'hCAFEF00D);

    // Port 0 holds req through its ack: a second access follows.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e.port = 1'b0; e.err = 1'b0; e.rdata = 32'hDEADBEEF;
      exp_q.push_back(e);
    end
    set_req(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    t1 = -1; t2 = -1;
    for (cyc = 1; cyc <= 20 && t2 < 0; cyc++) begin
      @(negedge clk);
      if (rq0_ack) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("hold_first_lat", 32'(t1), 32'd2);
    check("hold_gap", 32'(t2 - t1), 32'd3);

    // Reset pulsed during the ACCESS cycle of a write to address 9.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 32'd9, 32'h12345678);
    @(posedge clk);
    #2;
    check("abort_wr_active", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    check_outputs_zero("abort_async");
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_outputs_zero("abort_held");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_mem9", mem[9], 32'd9);

    // Fresh access after the aborted one.
    access(1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 32'd9);

    // Drain the scoreboard with a bounded wait.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
